// File: rtl/glb_stream_sink_if.sv
// Ready/valid handshake bundle carrying 17-bit sparse tokens into the sink.
interface glb_stream_sink_if;
  logic [16:0] data;
  logic        valid;
  logic        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glb_stream_sink.sv
// Stream sink for sparse token ports: throttled acceptance, capture buffer with
// registered readback, completion detection and cycle/token statistics.
//
// state  | meaning
// IDLE   | waiting for the first valid token
// ACTIVE | stream in progress, cycles being counted
// DONE   | TX_NUM done tokens received, sink closed until flush
module glb_stream_sink #(
  parameter int          DEPTH       = 256,
  parameter int          TX_NUM      = 1,
  parameter bit          THROTTLE_EN = 1'b1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     tile_en,
  glb_stream_sink_if.slave         stream,
  output logic                     done,
  output logic                     full,
  output logic [15:0]              token_count,
  output logic [15:0]              stop_count,
  output logic [31:0]              cycle_count,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [16:0]              rd_data
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [7:0] TX_LAST = 8'(TX_NUM - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_nxt;
  logic [AW:0] wr_ptr_q;
  logic [7:0]  done_cnt_q;
  logic [16:0] mem [DEPTH];
  logic        thr, xfer, is_done, is_stop, last_done, cyc_en;

  assign lfsr_nxt  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign thr       = THROTTLE_EN ? lfsr_q[0] : 1'b1;
  // wr_ptr never exceeds DEPTH, so its top bit alone marks a full buffer
  assign full      = wr_ptr_q[AW];
  assign done      = (state_q == DONE);
  assign stream.ready = tile_en & ~flush & ~done & ~full & thr;
  assign xfer      = stream.valid & stream.ready;
  assign is_done   = (stream.data == 17'h10100);
  assign is_stop   = stream.data[16] & (stream.data[15:8] == 8'h00);
  assign last_done = xfer & is_done & (done_cnt_q == TX_LAST);

  always_comb begin
    state_d = state_q;
    cyc_en  = 1'b0;
    if (tile_en) begin
      case (state_q)
        IDLE: begin
          if (stream.valid) begin
            cyc_en  = 1'b1;
            state_d = last_done ? DONE : ACTIVE;
          end
        end
        ACTIVE: begin
          cyc_en = 1'b1;
          if (last_done) state_d = DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (flush) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      lfsr_q      <= SEED;
      wr_ptr_q    <= '0;
      done_cnt_q  <= '0;
      token_count <= '0;
      stop_count  <= '0;
      cycle_count <= '0;
    end else begin
      if (tile_en) lfsr_q <= lfsr_nxt;
      if (cyc_en && cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
      if (xfer) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
        if (token_count != 16'hFFFF) token_count <= token_count + 16'd1;
        if (is_stop && stop_count != 16'hFFFF) stop_count <= stop_count + 16'd1;
        if (is_done && done_cnt_q != 8'hFF) done_cnt_q <= done_cnt_q + 8'd1;
      end
    end
  end

  // buffer survives flush so a harness can still read back the last run
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr_q[AW-1:0]] <= stream.data;
  end

  always_ff @(posedge clk) begin
    if (flush) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_glb_stream_sink.sv
// Directed bench for glb_stream_sink: four instances cover unthrottled, throttled,
// shallow-buffer and multi-done configurations.
module tb_glb_stream_sink;
  logic clk;
  logic flush;
  logic tile_en;
  int   n_cmp = 0;
  int   n_err = 0;

  glb_stream_sink_if if_a ();
  glb_stream_sink_if if_t ();
  glb_stream_sink_if if_d ();
  glb_stream_sink_if if_x ();

  logic        done_a, full_a, done_t, full_t, done_d, full_d, done_x, full_x;
  logic [15:0] tc_a, sc_a, tc_t, sc_t, tc_d, sc_d, tc_x, sc_x;
  logic [31:0] cyc_a, cyc_t, cyc_d, cyc_x;
  logic [7:0]  ra_a, ra_t, ra_x;
  logic [1:0]  ra_d;
  logic [16:0] rd_a, rd_t, rd_d, rd_x;
  logic [15:0] lfsr_m;

  glb_stream_sink #(.DEPTH(256), .TX_NUM(1), .THROTTLE_EN(1'b0), .SEED(16'hACE1)) u_a (
    .clk(clk), .flush(flush), .tile_en(tile_en), .stream(if_a), .done(done_a), .full(full_a),
    .token_count(tc_a), .stop_count(sc_a), .cycle_count(cyc_a), .rd_addr(ra_a), .rd_data(rd_a));

  glb_stream_sink #(.DEPTH(256), .TX_NUM(1), .THROTTLE_EN(1'b1), .SEED(16'hACE1)) u_t (
    .clk(clk), .flush(flush), .tile_en(tile_en), .stream(if_t), .done(done_t), .full(full_t),
    .token_count(tc_t), .stop_count(sc_t), .cycle_count(cyc_t), .rd_addr(ra_t), .rd_data(rd_t));

  glb_stream_sink #(.DEPTH(4), .TX_NUM(1), .THROTTLE_EN(1'b0), .SEED(16'hACE1)) u_d (
    .clk(clk), .flush(flush), .tile_en(tile_en), .stream(if_d), .done(done_d), .full(full_d),
    .token_count(tc_d), .stop_count(sc_d), .cycle_count(cyc_d), .rd_addr(ra_d), .rd_data(rd_d));

  glb_stream_sink #(.DEPTH(256), .TX_NUM(2), .THROTTLE_EN(1'b0), .SEED(16'hACE1)) u_x (
    .clk(clk), .flush(flush), .tile_en(tile_en), .stream(if_x), .done(done_x), .full(full_x),
    .token_count(tc_x), .stop_count(sc_x), .cycle_count(cyc_x), .rd_addr(ra_x), .rd_data(rd_x));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference Galois LFSR, x^16+x^14+x^13+x^11
  always @(posedge clk) begin
    if (flush)        lfsr_m <= 16'hACE1;
    else if (tile_en) lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int   acc;
    logic exp_r;

    flush = 1'b1; tile_en = 1'b1;
    if_a.valid = 1'b0; if_a.data = '0; if_t.valid = 1'b0; if_t.data = '0;
    if_d.valid = 1'b0; if_d.data = '0; if_x.valid = 1'b0; if_x.data = '0;
    ra_a = '0; ra_t = '0; ra_d = '0; ra_x = '0;

    // reset
    #2;
    chk("flush_ready", 32'(if_a.ready), 0);
    tick();
    chk("rst_done", 32'(done_a), 0);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_tc", 32'(tc_a), 0);
    chk("rst_sc", 32'(sc_a), 0);
    chk("rst_cyc", cyc_a, 0);
    chk("rst_rd", 32'(rd_a), 0);
    flush = 1'b0;
    #1;
    chk("idle_ready", 32'(if_a.ready), 1);

    // unthrottled 4-token stream ending with done
    if_a.valid = 1'b1; if_a.data = 17'h00005;
    tick(); if_a.data = 17'h00007;
    tick(); if_a.data = 17'h10000;
    tick(); if_a.data = 17'h10100;
    chk("a_ready_pre_done", 32'(if_a.ready), 1);
    chk("a_done_pre", 32'(done_a), 0);
    tick(); if_a.valid = 1'b0;
    chk("a_done", 32'(done_a), 1);
    chk("a_ready_done", 32'(if_a.ready), 0);
    chk("a_tc", 32'(tc_a), 4);
    chk("a_sc", 32'(sc_a), 1);
    chk("a_cyc", cyc_a, 4);
    ra_a = 8'd2;
    tick();
    chk("a_rd2", 32'(rd_a), 32'h10000);
    tick();
    chk("a_cyc_frozen", cyc_a, 4);

    // throttled sink, producer always valid, tokens numbered by acceptance
    acc = 0;
    if_t.valid = 1'b1; if_t.data = 17'd0;
    for (int i = 0; i < 40; i++) begin
      exp_r = lfsr_m[0];
      chk("t_ready", 32'(if_t.ready), 32'(exp_r));
      tick();
      if (exp_r) begin
        acc++;
        if_t.data = 17'(acc);
      end
    end
    if_t.valid = 1'b0;
    chk("t_tc", 32'(tc_t), 32'(acc));
    for (int i = 0; i < acc; i++) begin
      ra_t = 8'(i);
      tick();
      chk("t_rd", 32'(rd_t), 32'(i));
    end

    // DEPTH=4: six data tokens, tile_en pause after two
    if_d.valid = 1'b1; if_d.data = 17'h00011;
    chk("d_ready0", 32'(if_d.ready), 1);
    tick(); if_d.data = 17'h00012;
    tick(); if_d.data = 17'h00013;
    tile_en = 1'b0;
    #1;
    chk("d_ready_gated", 32'(if_d.ready), 0);
    tick(); tick();
    chk("d_tc_gated", 32'(tc_d), 2);
    chk("d_cyc_gated", cyc_d, 2);
    tile_en = 1'b1;
    #1;
    chk("d_ready_resume", 32'(if_d.ready), 1);
    tick();
    chk("d_full_3", 32'(full_d), 0);
    if_d.data = 17'h00014;
    tick(); if_d.data = 17'h00015;
    chk("d_full", 32'(full_d), 1);
    chk("d_ready_full", 32'(if_d.ready), 0);
    tick(); if_d.data = 17'h00016;
    tick();
    chk("d_tc_full", 32'(tc_d), 4);
    chk("d_done", 32'(done_d), 0);
    chk("d_ready_stall", 32'(if_d.ready), 0);
    if_d.valid = 1'b0;
    ra_d = 2'd3;
    tick();
    chk("d_rd3", 32'(rd_d), 32'h14);

    // TX_NUM=2
    if_x.valid = 1'b1; if_x.data = 17'h00001;
    tick(); if_x.data = 17'h10100;
    tick(); if_x.data = 17'h00002;
    chk("x_done_first", 32'(done_x), 0);
    chk("x_ready_first", 32'(if_x.ready), 1);
    tick(); if_x.data = 17'h10100;
    tick(); if_x.valid = 1'b0;
    chk("x_done", 32'(done_x), 1);
    chk("x_tc", 32'(tc_x), 4);
    chk("x_sc", 32'(sc_x), 0);

    // flush mid-stream then resend
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f_done_clr", 32'(done_a), 0);
    if_a.valid = 1'b1; if_a.data = 17'h00021;
    tick(); if_a.data = 17'h00022;
    tick();
    chk("f_tc_mid", 32'(tc_a), 2);
    if_a.data = 17'h00023; flush = 1'b1;
    #1;
    chk("f_ready_flush", 32'(if_a.ready), 0);
    tick();
    chk("f_tc_clr", 32'(tc_a), 0);
    chk("f_cyc_clr", cyc_a, 0);
    flush = 1'b0; if_a.data = 17'h00031;
    #1;
    chk("f_ready_rel", 32'(if_a.ready), 1);
    tick(); if_a.data = 17'h00032;
    tick(); if_a.data = 17'h10000;
    tick(); if_a.data = 17'h10100;
    chk("f_done_pre", 32'(done_a), 0);
    tick(); if_a.valid = 1'b0;
    chk("f_done", 32'(done_a), 1);
    chk("f_tc", 32'(tc_a), 4);
    chk("f_sc", 32'(sc_a), 1);
    chk("f_cyc", cyc_a, 4);
    ra_a = 8'd0;
    tick();
    chk("f_rd0", 32'(rd_a), 32'h31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
